// File: rtl/adder_pkg.sv
// Shared defaults and operation encoding for the pipelined adder.
package adder_pkg;
  localparam int ADDER_WIDTH  = 16;
  localparam int ADDER_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Subtract forces the +1 of the two's-complement negate into the carry chain.
  function automatic logic eff_cin(input logic sub, input logic cin);
    return (op_e'(sub) == OP_SUB) ? 1'b1 : cin;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder used as one pipeline stage's slice.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, global stall on back-pressure.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || (WIDTH < 2) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH (%0d) must be >= 2 and a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic              advance;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES-1:0] vld_q;

  // Whole pipe moves together; only a held result at the tail can block it.
  assign advance  = !vld_pipe[STAGES] || out_ready;
  assign in_ready = advance;
  assign vld_pipe = {vld_q, in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[STAGES-1:0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k*CHUNK;   // operand bits not yet summed
    localparam int LO  = (k+1)*CHUNK;       // sum bits complete after this stage

    logic [REM-1:0]   a_i, b_i;
    logic             c_i, co;
    logic [CHUNK-1:0] cs;
    logic [LO-1:0]    s_nxt, s_r;
    logic             c_r;

    if (k == 0) begin : g_head
      assign a_i   = a;
      assign b_i   = (op_e'(sub) == OP_SUB) ? ~b : b;
      assign c_i   = eff_cin(sub, cin);
      assign s_nxt = cs;
    end else begin : g_body
      assign a_i   = g_stage[k-1].g_fwd.a_r;
      assign b_i   = g_stage[k-1].g_fwd.b_r;
      assign c_i   = g_stage[k-1].c_r;
      assign s_nxt = {cs, g_stage[k-1].s_r};
    end

    adder_slice #(.W(CHUNK)) u_slice (
      .a  (a_i[CHUNK-1:0]),
      .b  (b_i[CHUNK-1:0]),
      .ci (c_i),
      .s  (cs),
      .co (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_r <= '0;
        c_r <= 1'b0;
      end else if (advance) begin
        s_r <= s_nxt;
        c_r <= co;
      end
    end

    if (k < STAGES-1) begin : g_fwd
      logic [REM-CHUNK-1:0] a_r, b_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance) begin
          a_r <= a_i[REM-1:CHUNK];
          b_r <= b_i[REM-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_r;
      // Operand signs agree but the result sign flipped.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovf_r <= 1'b0;
        else if (advance) ovf_r <= (a_i[REM-1] == b_i[REM-1]) && (cs[CHUNK-1] != a_i[REM-1]);
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign sum       = g_stage[STAGES-1].s_r;
  assign cout      = g_stage[STAGES-1].c_r;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_r;
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be a multiple of STAGES and at least 2.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; each stage adds one CHUNK = WIDTH/STAGES bit slice.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: operand set present on a, b, cin, sub.
REQ-006 Port in_ready, output, 1: pipeline accepts the operand set this cycle.
REQ-007 Port a, input, WIDTH: operand A.
REQ-008 Port b, input, WIDTH: operand B.
REQ-009 Port cin, input, 1: carry-in; ignored when sub=1.
REQ-010 Port sub, input, 1: 0 = add (a+b+cin), 1 = subtract (a-b).
REQ-011 Port out_valid, output, 1: result on sum, cout, ovf is valid.
REQ-012 Port out_ready, input, 1: downstream accepts the result.
REQ-013 Port sum, output, WIDTH: result modulo 2^WIDTH.
REQ-014 Port cout, output, 1: carry out of the MSB; for subtract, 1 = no borrow.
REQ-015 Port ovf, output, 1: two's-complement signed overflow.

Function
REQ-016 The block SHALL transfer an input when in_valid and in_ready are both 1, and an output when out_valid and out_ready are both 1.
REQ-017 Subtract SHALL be computed as a + ~b + 1 using the same adder path.
REQ-018 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK], register the chunk sum and chunk carry, and forward the not-yet-added upper operand bits unchanged.
REQ-019 Each stage SHALL register a valid bit; the final stage registers drive sum, cout, ovf and out_valid.
REQ-020 Latency SHALL be exactly STAGES cycles from input handshake to out_valid with no stall, and throughput SHALL be one result per cycle.
REQ-021 ovf SHALL be 1 iff the MSB operands (b inverted when sub=1) share a sign and the sum MSB differs from it.
REQ-022 Global stall: advance = !out_valid || out_ready; when advance=0 all stage registers SHALL hold.
REQ-023 in_ready SHALL equal advance, combinationally.
REQ-024 Bubbles: a stage whose valid is 0 SHALL not affect outputs; data registers of invalid stages are don't-care.
REQ-025 Held outputs SHALL stay bit-stable while out_valid=1 and out_ready=0.
REQ-026 A wrap-around (e.g. all-ones + 1) SHALL produce sum 0 with cout 1; no saturation.
REQ-027 Inputs presented while in_ready=0 SHALL be ignored, and no result SHALL be lost or duplicated.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately clear all stage valid bits, out_valid, sum, cout and ovf to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight operand sets; none SHALL appear after release.
REQ-030 in_ready SHALL be 1 during and after reset, because out_valid is 0.

Structure
REQ-031 Package adder_pkg SHALL hold default WIDTH/STAGES constants and the sub encoding (ADD=0, SUB=1).
REQ-032 Sub-module adder_slice (CHUNK-bit ripple add: a, b, ci -> s, co) SHALL be instantiated once per stage via generate.
REQ-033 Elaboration SHALL fail if WIDTH % STAGES != 0.

Verification (WIDTH=16, STAGES=4, out_ready=1 unless stated)
REQ-034 a=FFFF, b=0001, cin=0, sub=0 -> after 4 cycles sum=0000, cout=1, ovf=0.
REQ-035 a=0005, b=0007, sub=1 -> sum=FFFE, cout=0, ovf=0; a=7FFF, b=0001, sub=0 -> sum=8000, ovf=1.
REQ-036 8 back-to-back random sets streamed at 1 per cycle -> 8 results in order, first at cycle 4, all matching a reference model.
REQ-037 Stream with out_ready=0 for 3 cycles -> in_ready=0 and sum held stable; no results dropped or duplicated after release.
REQ-038 rst_n pulsed low with 3 sets in flight -> out_valid=0 immediately, and no stale result after release.
REQ-039 1000 random sets with mixed sub/cin/stall patterns, seeded -> zero mismatches against a+b+cin / a-b with carry and overflow.
